friscv_inst_mem_resp: RTL
=========================

# friscv_inst_mem_resp

Instruction-memory responder for the FRISCV control unit: the slave end of the `inst_en` / `inst_addr` / `inst_rdata` / `inst_ready` fetch interface. It holds a word-organised program RAM, preloaded through a loader write port. It answers each fetch after a configurable number of wait cycles and flags misaligned fetches. It sits between `friscv_rv32i_control` and the testbench or SoC program loader.

## Interface
- `ADDRW`, 16, byte-address width; RAM depth is 2^(ADDRW-2) words of XLEN bits
- `XLEN`, 32, instruction/data width
- `LATENCY`, 1, wait cycles from request acceptance to `inst_ready`; legal range 1..8
- `aclk` in 1 — single clock, all logic on rising edge
- `srstn` in 1 — reset; synchronous and active-low
- `inst_en` in 1 — fetch request; held with `inst_addr` until `inst_ready`
- `inst_addr` in ADDRW — byte address of the fetch
- `inst_rdata` out XLEN — fetched instruction, valid only while `inst_ready`=1
- `inst_ready` out 1 — single-cycle response strobe
- `inst_err` out 1 — misaligned-fetch flag, qualified by `inst_ready`
- `ld_wr` in 1 — loader word write strobe
- `ld_addr` in ADDRW-2 — loader word address
- `ld_data` in XLEN — loader write data

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `inst_en`=1 latches `inst_addr`, loads wait counter with LATENCY-1, goes to WAIT. If LATENCY=1, goes directly to the read cycle.
- WAIT: counter decrements each cycle. At 0, RAM read at latched word address `addr[ADDRW-1:2]`, then goes to RESP.
- RESP: `inst_ready`=1 for exactly one cycle with `inst_rdata`/`inst_err`, then back to IDLE. No request is accepted in the RESP cycle.
- Misaligned fetch (`addr[1:0]`≠0): full latency still applies. Response carries `inst_rdata`=0 and `inst_err`=1. RAM is not read.
- Address wrap: word index is taken modulo depth; no out-of-range case exists.
- Loader writes are accepted in any state, one word per cycle.
- Write/read collision on the same word in the read cycle is write-first: the response carries `ld_data`.
- `inst_en` dropping during WAIT is a protocol violation. The responder still completes and pulses `inst_ready`.
- Reset:
  - `inst_ready`=0, `inst_rdata`=0, `inst_err`=0, state IDLE, counter 0.
  - RAM contents are preserved.
  - Reset mid-WAIT aborts the fetch; no response is emitted.

## Timing
- Request first seen in IDLE at cycle N → `inst_ready` high in cycle N+LATENCY.
- Earliest next acceptance is cycle N+LATENCY+1; throughput is one fetch per LATENCY+1 cycles.
- `inst_rdata` and `inst_err` are registered. They return to 0 the cycle after RESP.
- Loader write at cycle M is visible to any read cycle ≥ M (same-cycle forwarding).

## Configuration
- `FRISCV_IMEM_STALL_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 at reset) advances every cycle.
  - On acceptance, LFSR[1:0] adds 0..3 extra wait cycles.
  - Purpose: exercise control-unit throttling.
- Undefined: latency is exactly LATENCY; no LFSR logic is present.

## Structure
- Package `friscv_imem_pkg`: FSM state enum, `IMEM_MAX_LATENCY`=8, LFSR seed and tap constants.
- Sub-module `friscv_imem_ram`: single-port-read, single-port-write word array with write-first forwarding and registered read data.
- FSM, counter, alignment check and LFSR live in the top module.
- Elaboration check: LATENCY outside 1..8 is a fatal error.

## Test plan
- Reset, LATENCY=1: load word 0 = 32'h00000013 via `ld_wr`, fetch addr 0 → `inst_ready` one cycle later with `inst_rdata`=32'h00000013, `inst_err`=0.
- LATENCY=4: fetch addr 16'h0004 holding 32'h0010_0093 → `inst_ready` exactly 4 cycles after acceptance, one cycle wide. Back-to-back fetch accepted the following cycle.
- Misaligned fetch addr 16'h0006 → after LATENCY, `inst_ready`=1, `inst_err`=1, `inst_rdata`=0.
- Collision: `ld_wr` to word 2 with 32'hDEADBEEF in the read cycle of a fetch to addr 16'h0008 → response returns 32'hDEADBEEF.
- `srstn` deasserted-low mid-WAIT (LATENCY=4, cycle 2) → no `inst_ready` ever emitted for that fetch, outputs 0. Previously loaded word 0 is still returned by the next fetch.
- With `FRISCV_IMEM_STALL_EN`, 64 sequential fetches → every latency in LATENCY..LATENCY+3, all data correct, `inst_ready` never two cycles in a row.

Source files
------------

// File: rtl/friscv_imem_pkg.sv
// ============================================================================
// Module  : friscv_imem_pkg
// Brief   : Shared types and constants for the FRISCV instruction-memory
//           responder: FSM state encoding, latency bound, stall-LFSR setup.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package friscv_imem_pkg;

    // Responder FSM encoding
    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_RESP = 2'd2
    } imem_state_t;

    // Largest legal LATENCY parameter
    localparam int IMEM_MAX_LATENCY = 8;

    // Wait counter width: covers max latency minus one plus three stall cycles
    localparam int IMEM_CNT_W = 4;

    // Stall LFSR: 8-bit Fibonacci, taps 8,6,5,4 (bit indices 7,5,4,3)
    localparam logic [7:0] IMEM_LFSR_SEED = 8'hA5;
    localparam logic [7:0] IMEM_LFSR_TAPS = 8'b1011_1000;

    // One LFSR step: shift left, feedback is the parity of the tapped bits
    function automatic logic [7:0] imem_lfsr_next(input logic [7:0] state);
        return {state[6:0], ^(state & IMEM_LFSR_TAPS)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/friscv_imem_ram.sv
// ============================================================================
// Module  : friscv_imem_ram
// Brief   : Word-organised program RAM. One write port, one read port,
//           write-first forwarding on a same-address collision, registered
//           read data that returns to zero in every cycle without a read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module friscv_imem_ram
    import friscv_imem_pkg::*;
#(
    parameter int AW   = 14,
    parameter int XLEN = 32
) (
    input  logic            aclk,
    input  logic            srstn,
    input  logic            rd_en_i,
    input  logic [AW-1:0]   rd_addr_i,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0] rd_data_o
);

    localparam int DEPTH = 1 << AW;

    logic [XLEN-1:0] mem_q [0:DEPTH-1];
    logic [XLEN-1:0] rd_data_q;
    logic [XLEN-1:0] rd_data_d;

    // Array storage is deliberately not reset so a program survives srstn
    always_ff @(posedge aclk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read mux: a write to the word being read wins; no read yields zero
    always_comb begin
        rd_data_d = '0;
        if (rd_en_i) begin
            if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
                rd_data_d = wr_data_i;
            end else begin
                rd_data_d = mem_q[rd_addr_i];
            end
        end
    end

    // Registered read data
    always_ff @(posedge aclk) begin
        if (!srstn) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/friscv_inst_mem_resp.sv
// ============================================================================
// Module  : friscv_inst_mem_resp
// Brief   : Instruction-fetch slave for the FRISCV control unit. Answers each
//           inst_en request after LATENCY cycles with a one-cycle inst_ready
//           strobe, flags misaligned fetches, hosts a loader-written RAM.
//           Optional macro FRISCV_IMEM_STALL_EN adds 0..3 pseudo-random wait
//           cycles per fetch from an 8-bit LFSR.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module friscv_inst_mem_resp
    import friscv_imem_pkg::*;
#(
    parameter int ADDRW   = 16,
    parameter int XLEN    = 32,
    parameter int LATENCY = 1
) (
    input  logic             aclk,
    input  logic             srstn,
    input  logic             inst_en,
    input  logic [ADDRW-1:0] inst_addr,
    output logic [XLEN-1:0]  inst_rdata,
    output logic             inst_ready,
    output logic             inst_err,
    input  logic             ld_wr,
    input  logic [ADDRW-3:0] ld_addr,
    input  logic [XLEN-1:0]  ld_data
);

    localparam int                    WAW    = ADDRW - 2;
    localparam logic [IMEM_CNT_W-1:0] LAT_M1 = IMEM_CNT_W'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > IMEM_MAX_LATENCY) begin : g_latency_check
            $fatal(1, "friscv_inst_mem_resp: LATENCY must be within 1..8");
        end
    endgenerate

    imem_state_t           state_q, state_d;
    logic [IMEM_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDRW-1:0]      addr_q, addr_d;
    logic                  err_q, err_d;
    logic                  rd_en;
    logic [WAW-1:0]        rd_addr;
    logic [IMEM_CNT_W-1:0] extra_wait;
    logic [IMEM_CNT_W-1:0] wait_init;

`ifdef FRISCV_IMEM_STALL_EN
    logic [7:0] lfsr_q;

    // Free-running stall LFSR, reseeded by reset
    always_ff @(posedge aclk) begin
        if (!srstn) begin
            lfsr_q <= IMEM_LFSR_SEED;
        end else begin
            lfsr_q <= imem_lfsr_next(lfsr_q);
        end
    end

    assign extra_wait = {{(IMEM_CNT_W-2){1'b0}}, lfsr_q[1:0]};
`else
    assign extra_wait = '0;
`endif

    // Cycles left before the read cycle, loaded on acceptance
    assign wait_init = LAT_M1 + extra_wait;

    // Next-state logic: the read cycle is the last cycle before RESP, so a
    // zero wait reads straight from inst_addr in the accepting IDLE cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        err_d   = 1'b0;
        rd_en   = 1'b0;
        rd_addr = addr_q[ADDRW-1:2];
        case (state_q)
            IMEM_IDLE: begin
                if (inst_en) begin
                    addr_d = inst_addr;
                    if (wait_init == '0) begin
                        rd_en   = (inst_addr[1:0] == 2'b00);
                        rd_addr = inst_addr[ADDRW-1:2];
                        err_d   = (inst_addr[1:0] != 2'b00);
                        cnt_d   = '0;
                        state_d = IMEM_RESP;
                    end else begin
                        cnt_d   = wait_init;
                        state_d = IMEM_WAIT;
                    end
                end
            end
            IMEM_WAIT: begin
                if (cnt_q <= IMEM_CNT_W'(1)) begin
                    rd_en   = (addr_q[1:0] == 2'b00);
                    err_d   = (addr_q[1:0] != 2'b00);
                    cnt_d   = '0;
                    state_d = IMEM_RESP;
                end else begin
                    cnt_d = cnt_q - IMEM_CNT_W'(1);
                end
            end
            IMEM_RESP: begin
                state_d = IMEM_IDLE;
            end
            default: begin
                state_d = IMEM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM, counter, latched address and error flag registers
    always_ff @(posedge aclk) begin
        if (!srstn) begin
            state_q <= IMEM_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    friscv_imem_ram #(
        .AW   (WAW),
        .XLEN (XLEN)
    ) u_ram (
        .aclk      (aclk),
        .srstn     (srstn),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .wr_en_i   (ld_wr),
        .wr_addr_i (ld_addr),
        .wr_data_i (ld_data),
        .rd_data_o (inst_rdata)
    );

    assign inst_ready = (state_q == IMEM_RESP);
    assign inst_err   = err_q;

endmodule

`default_nettype wire
